// File: rtl/pipelined_uniform_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_uniform_adder
// Description : Streaming adder/subtractor built from uniform BLOCK-bit
//               carry-select blocks. One block is resolved per pipeline stage,
//               so latency is NBLK cycles with one result per cycle. Valid/ready
//               handshakes are provided on both sides. A stalled output freezes
//               the whole pipe.
// Ports       : clk, rst_n (async, active low)
//               in_valid / in_ready   - operand handshake
//               inp1, inp2, cin, sub  - operands; sub=1 gives inp1-inp2
//               out_valid / out_ready - result handshake
//               out, cout             - result and MSB carry-out
//               ovf                   - signed overflow (ADDER_OVF_EN only)
// Options     : `define ADDER_OVF_EN adds the registered ovf output
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_uniform_adder #(
    parameter int WIDTH = 12,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NBLK = WIDTH / BLOCK;
    // Operand registers are only needed by stages that still have blocks to add.
    localparam int OPS  = (NBLK > 1) ? NBLK - 1 : 1;

    if ((WIDTH % BLOCK) != 0) begin : g_width_check
        $error("pipelined_uniform_adder: WIDTH must be a multiple of BLOCK");
    end

    logic                       w_adv;
    logic [WIDTH-1:0]           w_b_eff;
    logic                       w_c_eff;

    logic [NBLK-1:0]            r_valid;
    logic [NBLK-1:0]            r_carry;
    logic [NBLK-1:0][WIDTH-1:0] r_sum;
    logic [OPS-1:0][WIDTH-1:0]  r_a;
    logic [OPS-1:0][WIDTH-1:0]  r_b;

    logic [NBLK-1:0][WIDTH-1:0] w_nsum;
    logic [NBLK-1:0]            w_ncarry;

`ifdef ADDER_OVF_EN
    logic                       w_novf;
    logic                       r_ovf;
`endif

    // The pipe moves as one unit: it advances whenever the output slot is
    // empty or being drained this cycle.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_b_eff  = sub ? ~inp2 : inp2;
    assign w_c_eff  = sub | cin;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic [BLOCK-1:0] w_a_blk;
        logic [BLOCK-1:0] w_b_blk;
        logic [BLOCK:0]   w_res;

        if (k == 0) begin : g_first
            assign w_a_blk   = inp1[BLOCK-1:0];
            assign w_b_blk   = w_b_eff[BLOCK-1:0];
            assign w_res     = {1'b0, w_a_blk} + {1'b0, w_b_blk} + (BLOCK+1)'(w_c_eff);
            assign w_nsum[0] = WIDTH'(w_res[BLOCK-1:0]);
        end else begin : g_csel
            logic [BLOCK:0] w_s0;
            logic [BLOCK:0] w_s1;
            assign w_a_blk   = r_a[k-1][k*BLOCK +: BLOCK];
            assign w_b_blk   = r_b[k-1][k*BLOCK +: BLOCK];
            // Both carry-in cases are formed, then the previous stage's
            // registered carry picks one.
            assign w_s0      = {1'b0, w_a_blk} + {1'b0, w_b_blk};
            assign w_s1      = {1'b0, w_a_blk} + {1'b0, w_b_blk} + (BLOCK+1)'(1);
            assign w_res     = r_carry[k-1] ? w_s1 : w_s0;
            // Lower blocks pass through; this block's slot is still zero.
            assign w_nsum[k] = r_sum[k-1] | (WIDTH'(w_res[BLOCK-1:0]) << (k * BLOCK));
        end

        assign w_ncarry[k] = w_res[BLOCK];

`ifdef ADDER_OVF_EN
        if (k == NBLK - 1) begin : g_ovf
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            assign w_novf = w_a_blk[BLOCK-1] ^ w_b_blk[BLOCK-1]
                          ^ w_res[BLOCK-1] ^ w_res[BLOCK];
        end
`endif
    end

    // The last operand register is only partially consumed.
    logic w_unused_ops;
    assign w_unused_ops = ^{r_a[OPS-1], r_b[OPS-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_carry <= '0;
            r_sum   <= '0;
            r_a     <= '0;
            r_b     <= '0;
`ifdef ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_adv) begin
            r_valid[0] <= in_valid;
            for (int k = 1; k < NBLK; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
            r_sum   <= w_nsum;
            r_carry <= w_ncarry;
            r_a[0]  <= inp1;
            r_b[0]  <= w_b_eff;
            for (int k = 1; k < OPS; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
            end
`ifdef ADDER_OVF_EN
            r_ovf   <= w_novf;
`endif
        end
    end

    assign out_valid = r_valid[NBLK-1];
    assign out       = r_sum[NBLK-1];
    assign cout      = r_carry[NBLK-1];
`ifdef ADDER_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_uniform_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_uniform_adder
// Description : Self-checking bench for pipelined_uniform_adder (defaults
//               WIDTH=12, BLOCK=4). Expected results are queued on accepted
//               inputs and compared when results are handed off.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_uniform_adder;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] inp1 = '0;
    logic [W-1:0] inp2 = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         cout;
`ifdef ADDER_OVF_EN
    logic         ovf;
`endif

    pipelined_uniform_adder #(.WIDTH(W), .BLOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp1      (inp1),
        .inp2      (inp2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] o;
        logic         c;
        logic         v;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;
        logic [W-1:0] eo;
        logic         ec;
        logic         ev;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        logic [W-1:0] be;
        logic [W:0]   t;
        exp_t         r;
        be  = s ? ~b : b;
        t   = {1'b0, a} + {1'b0, be} + (W+1)'(s | c);
        r.o = t[W-1:0];
        r.c = t[W];
        r.v = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
        return r;
    endfunction

    // Results are compared at the falling edge preceding the handoff edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: out_valid=1 out=0x%0h with nothing outstanding", out);
            end else begin
                e = sb.pop_front();
                check("out", 32'(out), 32'(e.o));
                check("cout", 32'(cout), 32'(e.c));
`ifdef ADDER_OVF_EN
                check("ovf", 32'(ovf), 32'(e.v));
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input exp_t e);
        int waited = 0;
        inp1 = a; inp2 = b; cin = c; sub = s; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready low for %0d cycles", waited);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 32'(sb.size()), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        exp_t e;
        int   t0;
        tbl[0] = '{12'h003, 12'h002, 1'b0, 1'b0, 12'h005, 1'b0, 1'b0};
        tbl[1] = '{12'h800, 12'h802, 1'b0, 1'b0, 12'h002, 1'b1, 1'b1};
        tbl[2] = '{12'hFFF, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0};
        tbl[3] = '{12'h005, 12'h007, 1'b1, 1'b1, 12'hFFE, 1'b0, 1'b0};
        tbl[4] = '{12'h007, 12'h005, 1'b1, 1'b1, 12'h002, 1'b1, 1'b0};
        tbl[5] = '{12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1};
        tbl[6] = '{12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1};
        tbl[7] = '{12'h0F0, 12'h00F, 1'b1, 1'b0, 12'h100, 1'b0, 1'b0};
        tbl[8] = '{12'h000, 12'h000, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0};
        tbl[9] = '{12'hABC, 12'h123, 1'b0, 1'b0, 12'hBDF, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out", 32'(out), 0);
        check("rst_cout", 32'(cout), 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Latency: accepted at E, valid after E+2
        send(12'h000, 12'h002, 1'b0, 1'b0, '{12'h002, 1'b0, 1'b0});
        in_valid = 1'b0;
        check("lat_after_E", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_after_E1", 32'(out_valid), 1'b0);
        @(posedge clk); #1;
        check("lat_after_E2", 32'(out_valid), 1);
        drain("lat_drain");

        // Directed table, streamed back-to-back
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, '{tbl[i].eo, tbl[i].ec, tbl[i].ev});
        end
        in_valid = 1'b0;
        check("stream_rate_cycles", 32'(cyc - t0), 10);
        drain("table_drain");

        // Random operands with random output backpressure
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [W-1:0] ra, rb;
                    logic rc, rs;
                    ra = W'($urandom);
                    rb = W'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    send(ra, rb, rc, rs, model(ra, rb, rc, rs));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (150) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain("random_drain");

        // Backpressure: 4 back-to-back, stall 5 cycles once first result shows
        e = model(tbl[1].a, tbl[1].b, tbl[1].c, tbl[1].s);
        fork
            begin
                for (int i = 1; i < 5; i++) begin
                    send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, model(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s));
                end
                in_valid = 1'b0;
            end
            begin
                int k = 0;
                while (!out_valid && k < 50) begin
                    @(posedge clk); #1;
                    k++;
                end
                check("bp_valid_rise", 32'(out_valid), 1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    check("bp_in_ready", 32'(in_ready), 0);
                    check("bp_out_valid", 32'(out_valid), 1);
                    check("bp_out_stable", 32'(out), 32'(e.o));
                    check("bp_cout_stable", 32'(cout), 32'(e.c));
                end
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // Reset mid-flight
        send(12'h123, 12'h111, 1'b0, 1'b0, '{12'h234, 1'b0, 1'b0});
        send(12'h010, 12'h020, 1'b0, 1'b0, '{12'h030, 1'b0, 1'b0});
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_pre_valid", 32'(out_valid), 1);
        check("mid_rst_pre_out", 32'(out), 12'h234);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out", 32'(out), 0);
        check("mid_rst_cout", 32'(cout), 0);
`ifdef ADDER_OVF_EN
        check("mid_rst_ovf", 32'(ovf), 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_stale", 32'(out_valid), 0);
        send(12'h001, 12'h001, 1'b0, 1'b0, '{12'h002, 1'b0, 1'b0});
        in_valid = 1'b0;
        drain("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
